// File: rtl/pll_lock_seq_pkg.sv
// rtl/pll_lock_seq_pkg.sv - state encoding and timer sizing for the PLL lock sequencer
package pll_lock_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_RELEASE,
    S_RUN,
    S_PS,
    S_FAIL
  } state_t;

  // Width of the shared timer: must hold the longest interval any state measures.
  function automatic int timer_w(input int lock_wait, input int rst_hold,
                                 input int rel_span, input int ps_span);
    int m;
    m = lock_wait;
    if (rst_hold > m) m = rst_hold;
    if (rel_span > m) m = rel_span;
    if (ps_span > m) m = ps_span;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_seq_lock_sync.sv
// rtl/pll_lock_seq_lock_sync.sv - 2-FF synchronizer for asynchronous status inputs, clears to 0
module lock_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLLA lock supervisor: reset pulse, lock filter, retries, staged domain
// reset release and dynamic phase-step handshake, all on the free-running reference clock
module pll_lock_seq
  import pll_lock_seq_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int RST_HOLD    = 16,
  parameter int LOCK_FILTER = 64,
  parameter int LOCK_WAIT   = 27000,
  parameter int MAX_RETRY   = 3,
  parameter int REL_GAP     = 8,
  parameter int PS_PULSE_W  = 4,
  parameter int PS_GAP      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             restart,
  output logic             pll_reset,
  output logic [N_OUT-1:0] rst_out,
  output logic             locked,
  output logic             pll_fail,
  output logic [1:0]       retry_cnt,
  input  logic             ps_req,
  input  logic [2:0]       ps_sel_in,
  input  logic             ps_dir_in,
  output logic             ps_ack,
  output logic [2:0]       ps_sel,
  output logic             ps_dir,
  output logic             ps_pulse
);

  localparam int TW = timer_w(LOCK_WAIT, RST_HOLD, REL_GAP * N_OUT, PS_PULSE_W + PS_GAP);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [TW-1:0] T_RST_END   = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] T_WAIT_END  = TW'(LOCK_WAIT - 1);
  localparam logic [TW-1:0] T_PULSE_END = TW'(PS_PULSE_W - 1);
  localparam logic [TW-1:0] T_PS_END    = TW'(PS_PULSE_W + PS_GAP - 1);
  localparam logic [FW-1:0] F_END       = FW'(LOCK_FILTER - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_OUT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [FW-1:0] filt;
  logic [IW-1:0] rel_idx;
  logic          ps_armed;
  logic          lock_s;
  logic [1:0]    retry_next;
  logic [TW-1:0] rel_due;

  lock_sync #(.W(1)) u_lock_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  assign retry_next = retry_cnt + 2'd1;
  // Timer value on the cycle whose edge releases rst_out[rel_idx]; the timer keeps running across releases.
  assign rel_due    = TW'((int'(rel_idx) + 1) * REL_GAP - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_PLLRST;
      timer     <= '0;
      filt      <= '0;
      rel_idx   <= '0;
      ps_armed  <= 1'b1;
      pll_reset <= 1'b1;
      rst_out   <= '1;
      locked    <= 1'b0;
      pll_fail  <= 1'b0;
      retry_cnt <= '0;
      ps_ack    <= 1'b0;
      ps_pulse  <= 1'b0;
      ps_sel    <= '0;
      ps_dir    <= 1'b0;
    end else if (restart) begin
      state     <= S_PLLRST;
      timer     <= '0;
      filt      <= '0;
      rel_idx   <= '0;
      pll_reset <= 1'b1;
      rst_out   <= '1;
      locked    <= 1'b0;
      pll_fail  <= 1'b0;
      retry_cnt <= '0;
      ps_ack    <= 1'b0;
      ps_pulse  <= 1'b0;
      if (!ps_req) ps_armed <= 1'b1;
    end else begin
      ps_ack <= 1'b0;
      // A held request is served once; only a low ps_req re-arms the stepper.
      if (!ps_req) ps_armed <= 1'b1;

      if (!lock_s && (state == S_RELEASE || state == S_RUN || state == S_PS)) begin
        state     <= S_PLLRST;
        timer     <= '0;
        pll_reset <= 1'b1;
        rst_out   <= '1;
        locked    <= 1'b0;
        ps_pulse  <= 1'b0;
      end else begin
        case (state)
          S_PLLRST: begin
            if (timer == T_RST_END) begin
              state     <= S_WAIT;
              timer     <= '0;
              filt      <= '0;
              pll_reset <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_WAIT: begin
            if (lock_s && filt == F_END) begin
              state   <= S_RELEASE;
              timer   <= '0;
              rel_idx <= '0;
            end else if (timer == T_WAIT_END) begin
              retry_cnt <= retry_next;
              timer     <= '0;
              pll_reset <= 1'b1;
              if (retry_next == 2'(MAX_RETRY)) begin
                state    <= S_FAIL;
                pll_fail <= 1'b1;
              end else begin
                state <= S_PLLRST;
              end
            end else begin
              timer <= timer + 1'b1;
              filt  <= lock_s ? filt + 1'b1 : '0;
            end
          end

          S_RELEASE: begin
            if (timer == rel_due) begin
              rst_out[rel_idx] <= 1'b0;
              if (rel_idx == IDX_LAST) begin
                state     <= S_RUN;
                timer     <= '0;
                retry_cnt <= '0;
                locked    <= 1'b1;
              end else begin
                rel_idx <= rel_idx + 1'b1;
                timer   <= timer + 1'b1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_RUN: begin
            if (ps_req && ps_armed) begin
              state    <= S_PS;
              timer    <= '0;
              ps_sel   <= ps_sel_in;
              ps_dir   <= ps_dir_in;
              ps_pulse <= 1'b1;
            end
          end

          S_PS: begin
            if (timer == T_PS_END) begin
              state    <= S_RUN;
              timer    <= '0;
              ps_ack   <= 1'b1;
              ps_armed <= 1'b0;
            end else begin
              if (timer == T_PULSE_END) ps_pulse <= 1'b0;
              timer <= timer + 1'b1;
            end
          end

          S_FAIL: begin
          end

          default: begin
            state <= S_PLLRST;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - directed scoreboard bench for pll_lock_seq
module tb_pll_lock_seq;

  localparam int N_OUT       = 4;
  localparam int RST_HOLD    = 16;
  localparam int LOCK_FILTER = 64;
  localparam int LOCK_WAIT   = 500;
  localparam int MAX_RETRY   = 3;
  localparam int REL_GAP     = 8;
  localparam int PS_PULSE_W  = 4;
  localparam int PS_GAP      = 8;
  localparam int SYNC        = 2;
  // pll_lock rising edge to first rst_out release
  localparam int LOCK_LAT    = SYNC + LOCK_FILTER + REL_GAP;

  localparam int C_PLLRST_LO = 0;
  localparam int C_PLLRST_HI = 1;
  localparam int C_LOCKED    = 2;
  localparam int C_PULSE_HI  = 3;
  localparam int C_PULSE_LO  = 4;
  localparam int C_ACK       = 5;
  localparam int C_REL       = 6;
  localparam int C_RST1100   = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             pll_lock;
  logic             restart;
  logic             pll_reset;
  logic [N_OUT-1:0] rst_out;
  logic             locked;
  logic             pll_fail;
  logic [1:0]       retry_cnt;
  logic             ps_req;
  logic [2:0]       ps_sel_in;
  logic             ps_dir_in;
  logic             ps_ack;
  logic [2:0]       ps_sel;
  logic             ps_dir;
  logic             ps_pulse;

  always #5 clk = ~clk;

  pll_lock_seq #(
    .N_OUT(N_OUT), .RST_HOLD(RST_HOLD), .LOCK_FILTER(LOCK_FILTER), .LOCK_WAIT(LOCK_WAIT),
    .MAX_RETRY(MAX_RETRY), .REL_GAP(REL_GAP), .PS_PULSE_W(PS_PULSE_W), .PS_GAP(PS_GAP)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset), .rst_out(rst_out), .locked(locked), .pll_fail(pll_fail),
    .retry_cnt(retry_cnt), .ps_req(ps_req), .ps_sel_in(ps_sel_in), .ps_dir_in(ps_dir_in),
    .ps_ack(ps_ack), .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_pulse(ps_pulse)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   ack_count = 0;

  always @(negedge clk) if (ps_ack === 1'b1) ack_count <= ack_count + 1;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = 'x;
    end else begin
      e = sb.pop_front();
    end
    n_assert++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      C_PLLRST_LO: return pll_reset === 1'b0;
      C_PLLRST_HI: return pll_reset === 1'b1;
      C_LOCKED:    return locked === 1'b1;
      C_PULSE_HI:  return ps_pulse === 1'b1;
      C_PULSE_LO:  return ps_pulse === 1'b0;
      C_ACK:       return ps_ack === 1'b1;
      C_REL:       return rst_out !== '1;
      C_RST1100:   return rst_out === 4'b1100;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int n);
    n = 0;
    while (!cond(sel) && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic push_reset_values(input string tag);
    push({tag, "_pll_reset"}, 1);
    push({tag, "_rst_out"}, 4'hF);
    push({tag, "_locked"}, 0);
    push({tag, "_pll_fail"}, 0);
    push({tag, "_retry_cnt"}, 0);
    push({tag, "_ps_ack"}, 0);
    push({tag, "_ps_pulse"}, 0);
    push({tag, "_ps_sel"}, 0);
    push({tag, "_ps_dir"}, 0);
  endtask

  task automatic pop_reset_values();
    pop_check(pll_reset);
    pop_check(rst_out);
    pop_check(locked);
    pop_check(pll_fail);
    pop_check(retry_cnt);
    pop_check(ps_ack);
    pop_check(ps_pulse);
    pop_check(ps_sel);
    pop_check(ps_dir);
  endtask

  initial begin
    int n;
    int cnt;
    int ack_base;
    logic [3:0] ex;

    reset = 1'b1; pll_lock = 1'b0; restart = 1'b0;
    ps_req = 1'b0; ps_sel_in = '0; ps_dir_in = 1'b0;
    tick(3);
    push_reset_values("reset");
    pop_reset_values();
    reset = 1'b0;

    // 1: clean lock, staged release
    push("t1_rst_hold", RST_HOLD);
    wait_for(C_PLLRST_LO, 100, n);
    pop_check(n);
    tick(100);
    pll_lock = 1'b1;
    push("t1_lock_lat", LOCK_LAT);
    wait_for(C_REL, 300, n);
    pop_check(n);
    push("t1_rel0", 4'b1110);
    pop_check(rst_out);
    ex = 4'b1110;
    for (int i = 1; i < N_OUT; i++) begin
      tick(REL_GAP - 1);
      push("t1_rel_hold", ex);
      pop_check(rst_out);
      tick(1);
      ex = ex << 1;
      push("t1_rel_step", ex);
      pop_check(rst_out);
    end
    push("t1_locked", 1);
    pop_check(locked);
    push("t1_retry", 0);
    pop_check(retry_cnt);

    // 4: phase step, held request yields exactly one step
    ack_base = ack_count;
    ps_sel_in = 3'd2; ps_dir_in = 1'b1; ps_req = 1'b1;
    push("t4_pulse_start", 1);
    wait_for(C_PULSE_HI, 10, n);
    pop_check(n);
    push("t4_ps_sel", 2);
    pop_check(ps_sel);
    push("t4_ps_dir", 1);
    pop_check(ps_dir);
    ps_sel_in = 3'd7; ps_dir_in = 1'b0;
    push("t4_pulse_w", PS_PULSE_W);
    wait_for(C_PULSE_LO, 20, n);
    pop_check(n);
    push("t4_ack_gap", PS_GAP);
    wait_for(C_ACK, 30, n);
    pop_check(n);
    push("t4_ps_sel_stable", 2);
    pop_check(ps_sel);
    tick(1);
    push("t4_ack_width", 0);
    pop_check(ps_ack);
    cnt = 0;
    repeat (40) begin
      tick(1);
      if (ps_pulse === 1'b1) cnt++;
    end
    push("t4_held_pulses", 0);
    pop_check(cnt);
    push("t4_ack_count", 1);
    pop_check(ack_count - ack_base);
    ps_req = 1'b0;
    tick(2);

    // 5 + 3: lock loss in PS, relock through a 1-cycle glitch, request served after relock
    ack_base = ack_count;
    ps_sel_in = 3'd5; ps_dir_in = 1'b0; ps_req = 1'b1;
    push("t5_pulse_start", 1);
    wait_for(C_PULSE_HI, 10, n);
    pop_check(n);
    pll_lock = 1'b0;
    push("t5_abort_lat", SYNC + 1);
    wait_for(C_PLLRST_HI, 20, n);
    pop_check(n);
    push("t5_abort_pulse", 0);
    pop_check(ps_pulse);
    push("t5_abort_rst_out", 4'hF);
    pop_check(rst_out);
    push("t5_abort_locked", 0);
    pop_check(locked);
    push("t5_rst_hold", RST_HOLD);
    wait_for(C_PLLRST_LO, 40, n);
    pop_check(n);
    tick(10);
    pll_lock = 1'b1;
    tick(42);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    push("t3_glitch_lat", LOCK_LAT);
    wait_for(C_REL, 300, n);
    pop_check(n);
    push("t5_relock", (N_OUT - 1) * REL_GAP);
    wait_for(C_LOCKED, 100, n);
    pop_check(n);
    push("t5_no_ack_before_relock", 0);
    pop_check(ack_count - ack_base);
    push("t5_served", 1);
    wait_for(C_PULSE_HI, 10, n);
    pop_check(n);
    push("t5_ps_sel", 5);
    pop_check(ps_sel);
    push("t5_ack", PS_PULSE_W + PS_GAP);
    wait_for(C_ACK, 40, n);
    pop_check(n);
    ps_req = 1'b0;
    tick(2);
    push("t5_ack_count", 1);
    pop_check(ack_count - ack_base);

    // 6: lock loss in RUN, then reset in the middle of RELEASE
    pll_lock = 1'b0;
    push("t6_run_drop", SYNC + 1);
    wait_for(C_PLLRST_HI, 20, n);
    pop_check(n);
    push("t6_run_drop_rst_out", 4'hF);
    pop_check(rst_out);
    push("t6_run_drop_locked", 0);
    pop_check(locked);
    push("t6_rst_hold", RST_HOLD);
    wait_for(C_PLLRST_LO, 40, n);
    pop_check(n);
    pll_lock = 1'b1;
    push("t6_to_1100", LOCK_LAT + REL_GAP);
    wait_for(C_RST1100, 300, n);
    pop_check(n);
    reset = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    push_reset_values("t6_reset");
    pop_reset_values();
    tick(2);
    reset = 1'b0;

    // 2: lock never arrives, bounded retries, FAIL, restart
    for (int a = 1; a <= MAX_RETRY; a++) begin
      push("t2_rst_hold", RST_HOLD);
      wait_for(C_PLLRST_LO, 40, n);
      pop_check(n);
      push("t2_lock_wait", LOCK_WAIT);
      wait_for(C_PLLRST_HI, LOCK_WAIT + 20, n);
      pop_check(n);
      push("t2_retry_cnt", a);
      pop_check(retry_cnt);
    end
    push("t2_pll_fail", 1);
    pop_check(pll_fail);
    push("t2_fail_rst_out", 4'hF);
    pop_check(rst_out);
    ack_base = ack_count;
    ps_req = 1'b1;
    cnt = 0;
    repeat (50) begin
      tick(1);
      if (ps_pulse === 1'b1 || pll_reset !== 1'b1 || pll_fail !== 1'b1) cnt++;
    end
    ps_req = 1'b0;
    push("t2_fail_sticky", 0);
    pop_check(cnt);
    push("t2_fail_no_ack", 0);
    pop_check(ack_count - ack_base);
    tick(1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    push("t2_restart_fail", 0);
    pop_check(pll_fail);
    push("t2_restart_retry", 0);
    pop_check(retry_cnt);
    push("t2_restart_pll_reset", 1);
    pop_check(pll_reset);
    push("t2_restart_hold", RST_HOLD);
    wait_for(C_PLLRST_LO, 40, n);
    pop_check(n);
    pll_lock = 1'b1;
    push("t2_relock", LOCK_LAT + (N_OUT - 1) * REL_GAP);
    wait_for(C_LOCKED, 300, n);
    pop_check(n);
    push("t2_relock_rst_out", 0);
    pop_check(rst_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
